// File: rtl/uart_cmd_parser.sv
// UART command-packet engine: frames 5-byte command packets from the RX FIFO, drives register strobes, returns a 4-byte response.
// Optional inter-byte / read-wait timeout is enabled with `define UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter int unsigned       BITLEN         = 8,
    parameter logic [BITLEN-1:0] HEADER         = 8'hA5,
    parameter logic [BITLEN-1:0] CMD_WR         = 8'h01,
    parameter logic [BITLEN-1:0] CMD_RD         = 8'h02,
    parameter int unsigned       TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [BITLEN-1:0] rx_data,
    input  logic              rx_empty,
    output logic              rx_read,
    output logic [BITLEN-1:0] tx_data,
    output logic              tx_write,
    input  logic              tx_full,
    output logic [BITLEN-1:0] reg_addr,
    output logic [BITLEN-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [BITLEN-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT,
        S_RESP0, S_RESP1, S_RESP2, S_RESP3
    } state_t;

    localparam logic [BITLEN-1:0] ST_OK     = BITLEN'(0);
    localparam logic [BITLEN-1:0] ST_CHKERR = BITLEN'(1);
    localparam logic [BITLEN-1:0] ST_BADCMD = BITLEN'(2);

    state_t            state_q, state_d;
    logic [BITLEN-1:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
    logic [BITLEN-1:0] status_q, status_d, rdata_q, rdata_d;
    logic [BITLEN-1:0] reg_addr_q, reg_wdata_q;
    logic [7:0]        err_q;
    logic              load_reg, err_inc, pop, rx_state, tmo_hit;

    // Pops are gated by rstb so the FIFO is never drained while reset is held.
    assign rx_state = (state_q == S_IDLE) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
    assign pop      = rx_state && !rx_empty && rstb;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        wait_st;

    assign wait_st = (rx_state && state_q != S_IDLE) || (state_q == S_RDWAIT);
    assign tmo_hit = wait_st && !pop && !(state_q == S_RDWAIT && reg_rvalid) &&
                     (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    // Counts idle cycles; cleared by any pop or state change.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            tmo_q <= '0;
        else if (pop || (state_d != state_q) || !wait_st)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 32'd1;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        data_d   = data_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        load_reg = 1'b0;
        err_inc  = 1'b0;
        reg_wr   = 1'b0;
        reg_rd   = 1'b0;
        tx_write = 1'b0;
        tx_data  = '0;
        case (state_q)
            S_IDLE: if (pop && rx_data == HEADER) state_d = S_CMD;
            S_CMD:  if (pop) begin cmd_d  = rx_data; state_d = S_ADDR; end
            S_ADDR: if (pop) begin addr_d = rx_data; state_d = S_DATA; end
            S_DATA: if (pop) begin data_d = rx_data; state_d = S_CHK;  end
            S_CHK: begin
                if (pop) begin
                    if (rx_data != (cmd_q ^ addr_q ^ data_q)) begin
                        status_d = ST_CHKERR;
                        rdata_d  = '0;
                        err_inc  = 1'b1;
                        state_d  = S_RESP0;
                    end else begin
                        load_reg = 1'b1;
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cmd_q == CMD_WR) begin
                    reg_wr   = 1'b1;
                    status_d = ST_OK;
                    rdata_d  = '0;
                    state_d  = S_RESP0;
                end else if (cmd_q == CMD_RD) begin
                    reg_rd  = 1'b1;
                    state_d = S_RDWAIT;
                end else begin
                    status_d = ST_BADCMD;
                    rdata_d  = '0;
                    err_inc  = 1'b1;
                    state_d  = S_RESP0;
                end
            end
            S_RDWAIT: begin
                if (reg_rvalid) begin
                    rdata_d  = reg_rdata;
                    status_d = ST_OK;
                    state_d  = S_RESP0;
                end
            end
            S_RESP0: if (!tx_full) begin tx_write = 1'b1; tx_data = HEADER;             state_d = S_RESP1; end
            S_RESP1: if (!tx_full) begin tx_write = 1'b1; tx_data = status_q;           state_d = S_RESP2; end
            S_RESP2: if (!tx_full) begin tx_write = 1'b1; tx_data = rdata_q;            state_d = S_RESP3; end
            S_RESP3: if (!tx_full) begin tx_write = 1'b1; tx_data = status_q ^ rdata_q; state_d = S_IDLE;  end
            default: state_d = S_IDLE;
        endcase
        // A stalled body abandons the packet silently; a stalled read answers with status 03.
        if (tmo_hit) begin
            err_inc = 1'b1;
            if (state_q == S_RDWAIT) begin
                status_d = BITLEN'(3);
                rdata_d  = '0;
                state_d  = S_RESP0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            err_q       <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            if (load_reg) begin
                reg_addr_q  <= addr_q;
                reg_wdata_q <= data_q;
            end
            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    assign rx_read   = pop;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: RX FIFO model, TX/strobe monitor, expected-response scoreboard.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_full = 1'b0;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_wr, reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rstb(rstb),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
        .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .busy(busy), .err_count(err_count)
    );

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    int         got_cyc[$];
    int         cyc = 0;
    int         wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, pop_cyc = 0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
    int         n_chk = 0, n_pass = 0;
    int         exp_err = 0;

    // RX FIFO: pop on the active edge, present the new head on the falling edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_read && rx_q.size() > 0) void'(rx_q.pop_front());
    end

    always @(negedge clk) begin
        rx_empty <= (rx_q.size() == 0);
        rx_data  <= (rx_q.size() == 0) ? 8'h00 : rx_q[0];
        if (tx_write) begin
            got_tx.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (reg_wr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= reg_addr;
            wr_data <= reg_wdata;
            wr_cyc  <= cyc;
        end
        if (reg_rd) rd_cnt <= rd_cnt + 1;
        if (rx_read) pop_cyc <= cyc;
    end

    task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
        rx_q.push_back(b0); rx_q.push_back(b1); rx_q.push_back(b2);
        rx_q.push_back(b3); rx_q.push_back(b4);
    endtask

    task automatic expect_resp(input logic [7:0] st, input logic [7:0] rd);
        exp_tx.push_back(8'hA5); exp_tx.push_back(st);
        exp_tx.push_back(rd);    exp_tx.push_back(st ^ rd);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && got_tx.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if ({busy, rx_read, tx_write, reg_wr, reg_rd} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, rx_read, tx_write, reg_wr, reg_rd}); else n_pass++;
        n_chk++; if ({tx_data, reg_addr, reg_wdata} !== 24'h0)
            $display("FAIL reset_data: got %h expected 000000", {tx_data, reg_addr, reg_wdata}); else n_pass++;
        n_chk++; if (err_count !== 8'h00)
            $display("FAIL reset_err: got %h expected 00", err_count); else n_pass++;
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0)
            $display("FAIL reset_idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_write;
        logic [7:0] e, g;
        int wr0 = wr_cnt;
        push5(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D);
        expect_resp(8'h00, 8'h00);
        wait_tx(4);
        n_chk++; if (got_cyc.size() < 1 || got_cyc[0] - wr_cyc !== 1 || wr_cyc - pop_cyc !== 1)
            $display("FAIL write_latency: pop %0d wr %0d tx %0d expected consecutive cycles", pop_cyc, wr_cyc,
                     (got_cyc.size() > 0) ? got_cyc[0] : -1); else n_pass++;
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL write_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL write_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        n_chk++; if (wr_cnt - wr0 !== 1 || wr_addr !== 8'h10 || wr_data !== 8'h5C)
            $display("FAIL write_strobe: got n=%0d addr=%h data=%h expected n=1 addr=10 data=5C",
                     wr_cnt - wr0, wr_addr, wr_data); else n_pass++;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || err_count !== 8'(exp_err))
            $display("FAIL write_after: got busy=%b err=%h expected busy=0 err=%h", busy, err_count, 8'(exp_err)); else n_pass++;
    endtask

    task automatic test_read;
        logic [7:0] e, g;
        int rd0 = rd_cnt;
        bit seen = 1'b0;
        push5(8'hA5, 8'h02, 8'h20, 8'h00, 8'h22);
        expect_resp(8'h00, 8'h3C);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = reg_rd;
        end
        n_chk++; if (seen !== 1'b1) $display("FAIL read_strobe_seen: got 0 expected 1"); else n_pass++;
        repeat (3) @(negedge clk);
        reg_rdata = 8'h3C; reg_rvalid = 1'b1;
        @(negedge clk);
        reg_rdata = 8'h00; reg_rvalid = 1'b0;
        wait_tx(4);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL read_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL read_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        n_chk++; if (rd_cnt - rd0 !== 1 || reg_addr !== 8'h20)
            $display("FAIL read_pulse: got n=%0d addr=%h expected n=1 addr=20", rd_cnt - rd0, reg_addr); else n_pass++;
    endtask

    task automatic test_bad_chk;
        logic [7:0] e, g;
        int wr0 = wr_cnt;
        push5(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h00);
        expect_resp(8'h01, 8'h00);
        exp_err++;
        wait_tx(4);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL badchk_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL badchk_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        @(negedge clk);
        n_chk++; if (wr_cnt !== wr0 || err_count !== 8'(exp_err) || reg_addr !== 8'h20)
            $display("FAIL badchk_state: got wr=%0d err=%h addr=%h expected wr=%0d err=%h addr=20",
                     wr_cnt, err_count, reg_addr, wr0, 8'(exp_err)); else n_pass++;
    endtask

    task automatic test_bad_op;
        logic [7:0] e, g;
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
        push5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
        expect_resp(8'h02, 8'h00);
        exp_err++;
        wait_tx(4);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL badop_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL badop_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        @(negedge clk);
        n_chk++; if (err_count !== 8'(exp_err))
            $display("FAIL badop_err: got %h expected %h", err_count, 8'(exp_err)); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [7:0] e, g;
        bit seen = 1'b0, bad = 1'b0;
        tx_full = 1'b1;
        push5(8'hA5, 8'h01, 8'h33, 8'h44, 8'h76);
        expect_resp(8'h00, 8'h00);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = reg_wr;
        end
        repeat (20) begin
            @(negedge clk);
            if (tx_write || !busy) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0 || got_tx.size() !== 0)
            $display("FAIL bp_hold: got stall_violation=%b bytes=%0d expected 0 and 0", bad, got_tx.size()); else n_pass++;
        tx_full = 1'b0;
        wait_tx(4);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL bp_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL bp_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, g;
        int wr0 = wr_cnt;
        push5(8'hA5, 8'h01, 8'h40, 8'h11, 8'h50);
        push5(8'hA5, 8'h01, 8'h41, 8'h22, 8'h62);
        expect_resp(8'h00, 8'h00);
        expect_resp(8'h00, 8'h00);
        wait_tx(8);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL b2b_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL b2b_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        n_chk++; if (wr_cnt - wr0 !== 2 || wr_addr !== 8'h41 || wr_data !== 8'h22)
            $display("FAIL b2b_strobe: got n=%0d addr=%h data=%h expected n=2 addr=41 data=22",
                     wr_cnt - wr0, wr_addr, wr_data); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] e, g;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01);
        repeat (6) @(negedge clk);
        n_chk++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else n_pass++;
        rstb = 1'b0;
        #1;
        n_chk++; if ({busy, tx_write, reg_wr, reg_rd, rx_read} !== 5'b0 || err_count !== 8'h00 || reg_addr !== 8'h00)
            $display("FAIL rstmid_outputs: got ctrl=%b err=%h addr=%h expected 00000 00 00",
                     {busy, tx_write, reg_wr, reg_rd, rx_read}, err_count, reg_addr); else n_pass++;
        @(negedge clk);
        rstb = 1'b1;
        exp_err = 0;
        @(negedge clk);
        push5(8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D);
        expect_resp(8'h00, 8'h00);
        wait_tx(4);
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL rstmid_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL rstmid_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        n_chk++; if (reg_addr !== 8'h10 || reg_wdata !== 8'h5C)
            $display("FAIL rstmid_regs: got addr=%h data=%h expected 10 5C", reg_addr, reg_wdata); else n_pass++;
    endtask

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    task automatic test_timeout;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01);
        exp_err++;
        repeat (60) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || err_count !== 8'(exp_err) || got_tx.size() !== 0)
            $display("FAIL timeout: got busy=%b err=%h bytes=%0d expected 0 %h 0",
                     busy, err_count, got_tx.size(), 8'(exp_err)); else n_pass++;
        got_tx.delete(); got_cyc.delete();
    endtask
`endif

    task automatic test_err_saturate;
        logic [7:0] e, g;
        for (int i = 0; i < 260; i++) begin
            exp_tx.delete(); got_tx.delete(); got_cyc.delete();
            push5(8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF);
            expect_resp(8'h01, 8'h00);
            if (exp_err < 255) exp_err++;
            wait_tx(4);
        end
        n_chk++; if (got_tx.size() !== exp_tx.size())
            $display("FAIL sat_tx_count: got %0d expected %0d", got_tx.size(), exp_tx.size()); else n_pass++;
        while (exp_tx.size() > 0 && got_tx.size() > 0) begin
            e = exp_tx.pop_front(); g = got_tx.pop_front();
            n_chk++; if (g !== e) $display("FAIL sat_tx_byte: got %h expected %h", g, e); else n_pass++;
        end
        exp_tx.delete(); got_tx.delete(); got_cyc.delete();
        @(negedge clk);
        n_chk++; if (err_count !== 8'(exp_err))
            $display("FAIL sat_err: got %h expected %h", err_count, 8'(exp_err)); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_bad_chk;
        test_bad_op;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        test_timeout;
`endif
        test_err_saturate;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d/%0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Command-packet engine between the uart block's RX/TX FIFOs and the on-chip register bus.
- Pops bytes from the UART RX FIFO, frames and checks 5-byte command packets, and issues register write/read strobes.
- Pushes a 4-byte response packet into the UART TX FIFO.
- Downstream of uart data_out/out_read; upstream of uart data_in/in_write.

Parameters:
BITLEN, 8, byte width; must match uart BITLEN
HEADER, 8'hA5, packet start marker
CMD_WR, 8'h01, register write opcode
CMD_RD, 8'h02, register read opcode
TIMEOUT_CYCLES, 100000, inter-byte / read-wait timeout in clk cycles (timeout feature only)

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
rx_data  in  BITLEN  head of UART RX FIFO (first-word-fall-through, valid while rx_empty=0)
rx_empty  in  1  UART RX FIFO empty
rx_read  out  1  one-cycle pop of UART RX FIFO
tx_data  out  BITLEN  byte to UART TX FIFO
tx_write  out  1  one-cycle push to UART TX FIFO
tx_full  in  1  UART TX FIFO full
reg_addr  out  BITLEN  register address
reg_wdata  out  BITLEN  register write data
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read strobe
reg_rdata  in  BITLEN  read data, sampled when reg_rvalid=1
reg_rvalid  in  1  read data valid
busy  out  1  1 whenever state != IDLE
err_count  out  8  saturating count of rejected packets

Behaviour:
- Reset (rstb=0, async): state=IDLE; rx_read, tx_write, reg_wr, reg_rd, busy = 0; tx_data, reg_addr, reg_wdata, err_count = 0. Reset mid-packet discards the packet; no response is sent.
- Packet in: HEADER, CMD, ADDR, DATA, CHK, where CHK = CMD^ADDR^DATA.
- Response out: HEADER, STATUS, RDATA, RCHK, where RCHK = STATUS^RDATA.
- STATUS values:
  - 00 = ok
  - 01 = checksum error
  - 02 = unknown command
- RDATA = read data for CMD_RD; 00 otherwise.
- Byte pop rule:
  - In a receive state with rx_empty=0, assert rx_read for exactly one cycle and capture rx_data in that same cycle.
  - Then advance.
  - Maximum one pop per cycle; back-to-back pops are allowed.
- States:
  - IDLE: pop bytes; byte==HEADER -> CMD; any other byte is dropped silently (no err_count change).
  - CMD -> ADDR -> DATA -> CHK: pop and store one byte each. A HEADER value inside the body is treated as data, not a resync.
  - CHK: on pop, if checksum mismatches -> status 01, RESP0, err_count+1; else EXEC.
  - EXEC (1 cycle):
    - CMD_WR: reg_addr/reg_wdata driven, reg_wr=1 this cycle, status 00 -> RESP0.
    - CMD_RD: reg_rd=1 -> RDWAIT.
    - Other opcode: status 02, err_count+1 -> RESP0.
  - RDWAIT: on reg_rvalid=1, latch reg_rdata -> RESP0. reg_rvalid is allowed in the cycle after reg_rd at the earliest.
  - RESP0..RESP3: when tx_full=0, drive tx_data and pulse tx_write for one cycle, then advance. When tx_full=1, hold the state with tx_write=0. RESP3 -> IDLE.
- reg_addr/reg_wdata stay stable from EXEC until the next EXEC.
- err_count saturates at 8'hFF.
- No RX pops during EXEC/RDWAIT/RESPn; incoming bytes remain queued in the UART RX FIFO.
- Best-case latency, write packet: last byte pop -> reg_wr 1 cycle later -> first tx_write 1 cycle after that.

Optional Feature:
UART_CMD_PARSER_TIMEOUT_EN:
- Defined:
  - A counter resets on every pop and on every state change.
  - In CMD/ADDR/DATA/CHK, reaching TIMEOUT_CYCLES idle cycles -> IDLE, err_count+1, no response.
  - In RDWAIT, reaching TIMEOUT_CYCLES -> status 03 (timeout), RDATA 00, RESP0, err_count+1.
- Not defined: no counter logic; CMD..CHK and RDWAIT wait indefinitely; status 03 is never produced.

Test Plan:
- Write: RX bytes A5,01,10,5C,4D -> reg_wr one cycle with reg_addr=10, reg_wdata=5C; TX bytes A5,00,00,00; err_count=0.
- Read: RX A5,02,20,00,22; reg_rvalid with reg_rdata=3C three cycles after reg_rd -> one reg_rd pulse; TX A5,00,3C,3C.
- Bad checksum: RX A5,01,10,5C,00 -> no reg_wr; TX A5,01,00,01; err_count=1.
- Bad opcode plus garbage: RX 00,FF,A5,07,00,00,07 -> leading 00,FF dropped; TX A5,02,00,02; err_count=1.
- Backpressure: hold tx_full=1 during write response for 20 cycles -> no tx_write, state held; release -> 4 bytes emitted in order, then busy=0.
- Reset mid-packet: pulse rstb low after A5,01 -> all outputs reset, no TX; next full write packet is processed normally. With UART_CMD_PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=50: A5,01 then stall 60 cycles -> IDLE, err_count=1.
